// File: rtl/mtsp_sf_sequencer.sv
// MTSP special-function issue sequencer: serializes 4-lane SF instructions from
// two thread phases onto one scalar SF slot and tracks them to write-back.
module mtsp_sf_sequencer #(
    parameter int SF_LATENCY = 3,
    parameter int OP_W       = 3
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            REQ0_VALID,
    output logic            REQ0_READY,
    input  logic [3:0]      REQ0_MASK,
    input  logic [OP_W-1:0] REQ0_OP,
    input  logic            REQ1_VALID,
    output logic            REQ1_READY,
    input  logic [3:0]      REQ1_MASK,
    input  logic [OP_W-1:0] REQ1_OP,
    input  logic            HOLD,
    output logic            ISSUE_VALID,
    output logic            ISSUE_PHASE,
    output logic [3:0]      ISSUE_LANE,
    output logic [OP_W-1:0] ISSUE_OP,
    output logic            WB_VALID,
    output logic            WB_PHASE,
    output logic [3:0]      WB_LANE,
    output logic            DONE0,
    output logic            DONE1
);

    typedef struct packed {
        logic       vld;
        logic       ph;
        logic [3:0] lane;
        logic       last;
    } wb_ent_t;

    logic [1:0]           req_vld;
    logic [1:0][3:0]      req_mask;
    logic [1:0][OP_W-1:0] req_op;
    logic [1:0]           ready;

    logic [1:0][3:0]      rem_q, rem_d;
    logic [1:0][OP_W-1:0] op_q, op_d;
    logic [1:0]           zero_q, zero_d;
    logic                 last_q, last_d;

    logic                 iss_vld_q, iss_vld_d;
    logic                 iss_ph_q, iss_ph_d;
    logic [3:0]           iss_lane_q, iss_lane_d;
    logic [OP_W-1:0]      iss_op_q, iss_op_d;
    logic                 iss_last_q, iss_last_d;

    wb_ent_t [SF_LATENCY-1:0] pipe_q, pipe_d;
    wb_ent_t              wb;

    logic [1:0]           cand;
    logic                 gnt_vld;
    logic                 gnt_ph;
    logic [3:0]           gnt_rem;
    logic [3:0]           gnt_lane;
    logic [3:0]           gnt_left;

    function automatic logic [3:0] msb_onehot(input logic [3:0] r);
        if (r[3])      return 4'b1000;
        else if (r[2]) return 4'b0100;
        else if (r[1]) return 4'b0010;
        else if (r[0]) return 4'b0001;
        else           return 4'b0000;
    endfunction

    assign req_vld  = {REQ1_VALID, REQ0_VALID};
    assign req_mask = {REQ1_MASK, REQ0_MASK};
    assign req_op   = {REQ1_OP, REQ0_OP};

    // A phase is busy while lanes remain or an empty instruction awaits DONE.
    assign ready[0] = (rem_q[0] == 4'b0000) & ~zero_q[0];
    assign ready[1] = (rem_q[1] == 4'b0000) & ~zero_q[1];

    assign REQ0_READY = ready[0];
    assign REQ1_READY = ready[1];

    always_comb begin
        cand     = {|rem_q[1], |rem_q[0]};
        gnt_vld  = ~HOLD & (|cand);
        gnt_ph   = (&cand) ? ~last_q : cand[1];
        gnt_rem  = rem_q[gnt_ph];
        gnt_lane = msb_onehot(gnt_rem);
        gnt_left = gnt_rem & ~gnt_lane;
    end

    always_comb begin
        rem_d  = rem_q;
        op_d   = op_q;
        zero_d = 2'b00;
        last_d = last_q;

        iss_vld_d  = 1'b0;
        iss_ph_d   = iss_ph_q;
        iss_lane_d = iss_lane_q;
        iss_op_d   = iss_op_q;
        iss_last_d = iss_last_q;

        // Accepts only happen on empty phases, so they never collide with a grant.
        for (int p = 0; p < 2; p++) begin
            if (req_vld[p] && ready[p]) begin
                rem_d[p]  = req_mask[p];
                op_d[p]   = req_op[p];
                zero_d[p] = (req_mask[p] == 4'b0000);
            end
        end

        if (gnt_vld) begin
            rem_d[gnt_ph] = gnt_left;
            last_d        = gnt_ph;
            iss_vld_d     = 1'b1;
            iss_ph_d      = gnt_ph;
            iss_lane_d    = gnt_lane;
            iss_op_d      = op_q[gnt_ph];
            iss_last_d    = (gnt_left == 4'b0000);
        end
    end

    // The SF datapath never stalls, so tracking shifts every cycle.
    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = {iss_vld_q, iss_ph_q, iss_lane_q, iss_last_q};
        for (int i = 1; i < SF_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rem_q      <= '0;
            op_q       <= '0;
            zero_q     <= 2'b00;
            last_q     <= 1'b1;
            iss_vld_q  <= 1'b0;
            iss_ph_q   <= 1'b0;
            iss_lane_q <= 4'b0000;
            iss_op_q   <= '0;
            iss_last_q <= 1'b0;
            pipe_q     <= '0;
        end else begin
            rem_q      <= rem_d;
            op_q       <= op_d;
            zero_q     <= zero_d;
            last_q     <= last_d;
            iss_vld_q  <= iss_vld_d;
            iss_ph_q   <= iss_ph_d;
            iss_lane_q <= iss_lane_d;
            iss_op_q   <= iss_op_d;
            iss_last_q <= iss_last_d;
            pipe_q     <= pipe_d;
        end
    end

    assign wb = pipe_q[SF_LATENCY-1];

    assign ISSUE_VALID = iss_vld_q;
    assign ISSUE_PHASE = iss_ph_q;
    assign ISSUE_LANE  = iss_lane_q;
    assign ISSUE_OP    = iss_op_q;

    assign WB_VALID = wb.vld;
    assign WB_PHASE = wb.ph;
    assign WB_LANE  = wb.lane;

    assign DONE0 = (wb.vld & wb.last & ~wb.ph) | zero_q[0];
    assign DONE1 = (wb.vld & wb.last &  wb.ph) | zero_q[1];

endmodule

// File: tb/tb_mtsp_sf_sequencer.sv
// Bench for mtsp_sf_sequencer: directed scenarios plus random traffic
// compared against a queue-based behavioural model.
module tb_mtsp_sf_sequencer;

    localparam int OP_W = 3;
    localparam int LAT  = 3;

    logic            CLK = 1'b0;
    logic            RST;
    logic            REQ0_VALID, REQ1_VALID;
    logic            REQ0_READY, REQ1_READY;
    logic [3:0]      REQ0_MASK, REQ1_MASK;
    logic [OP_W-1:0] REQ0_OP, REQ1_OP;
    logic            HOLD;
    logic            ISSUE_VALID, ISSUE_PHASE;
    logic [3:0]      ISSUE_LANE;
    logic [OP_W-1:0] ISSUE_OP;
    logic            WB_VALID, WB_PHASE;
    logic [3:0]      WB_LANE;
    logic            DONE0, DONE1;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    mtsp_sf_sequencer #(.SF_LATENCY(LAT), .OP_W(OP_W)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY),
        .REQ0_MASK(REQ0_MASK), .REQ0_OP(REQ0_OP),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY),
        .REQ1_MASK(REQ1_MASK), .REQ1_OP(REQ1_OP),
        .HOLD(HOLD),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_PHASE(ISSUE_PHASE),
        .ISSUE_LANE(ISSUE_LANE), .ISSUE_OP(ISSUE_OP),
        .WB_VALID(WB_VALID), .WB_PHASE(WB_PHASE), .WB_LANE(WB_LANE),
        .DONE0(DONE0), .DONE1(DONE1)
    );

    // Behavioural model: per-phase queues of lane indices (3=X .. 0=W)
    typedef struct {
        int due;
        bit ph;
        int lane;
        bit lst;
    } wb_rec_t;

    int              mq0[$];
    int              mq1[$];
    wb_rec_t         wbq[$];
    bit [1:0]        m_zero;
    bit              m_last;
    logic [OP_W-1:0] m_op0, m_op1;
    int              m_cyc;
    bit              e_iv, e_ip, e_wv, e_wp, e_wlst;
    logic [3:0]      e_il, e_wl;
    logic [OP_W-1:0] e_io;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs;
        RST = 1'b0;
        HOLD = 1'b0;
        REQ0_VALID = 1'b0; REQ0_MASK = 4'b0; REQ0_OP = '0;
        REQ1_VALID = 1'b0; REQ1_MASK = 4'b0; REQ1_OP = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic model_edge(input bit rst, input bit v0, input bit v1,
                              input logic [3:0] k0, input logic [3:0] k1,
                              input logic [OP_W-1:0] o0,
                              input logic [OP_W-1:0] o1, input bit hold);
        bit r0, r1, c0, c1, g, lst;
        int ln;
        m_cyc++;
        e_wv = 1'b0;
        if (rst) begin
            mq0.delete(); mq1.delete(); wbq.delete();
            m_zero = 2'b00; m_last = 1'b1;
            e_iv = 0; e_ip = 0; e_il = 4'b0; e_io = '0;
            return;
        end
        r0 = (mq0.size() == 0) && !m_zero[0];
        r1 = (mq1.size() == 0) && !m_zero[1];
        c0 = mq0.size() > 0;
        c1 = mq1.size() > 0;
        e_iv = 1'b0;
        if (!hold && (c0 || c1)) begin
            g = (c0 && c1) ? !m_last : c1;
            if (g == 1'b0) begin
                ln = mq0.pop_front(); lst = (mq0.size() == 0); e_io = m_op0;
            end else begin
                ln = mq1.pop_front(); lst = (mq1.size() == 0); e_io = m_op1;
            end
            e_iv = 1'b1; e_ip = g; e_il = 4'(1 << ln);
            m_last = g;
            wbq.push_back('{m_cyc + LAT, g, ln, lst});
        end
        m_zero = 2'b00;
        if (v0 && r0) begin
            m_op0 = o0;
            if (k0 == 4'b0) m_zero[0] = 1'b1;
            for (int l = 3; l >= 0; l--) if (k0[l]) mq0.push_back(l);
        end
        if (v1 && r1) begin
            m_op1 = o1;
            if (k1 == 4'b0) m_zero[1] = 1'b1;
            for (int l = 3; l >= 0; l--) if (k1[l]) mq1.push_back(l);
        end
        if (wbq.size() > 0 && wbq[0].due == m_cyc) begin
            wb_rec_t w;
            w = wbq.pop_front();
            e_wv = 1'b1; e_wp = w.ph; e_wl = 4'(1 << w.lane); e_wlst = w.lst;
        end
    endtask

    task automatic test_reset;
        idle_inputs();
        RST = 1'b1;
        tick();
        tick();
        checks++;
        if ({REQ0_READY, REQ1_READY} !== 2'b11) begin
            failures++;
            $display("FAIL reset_ready got=%b want=11", {REQ0_READY, REQ1_READY});
        end
        checks++;
        if ({ISSUE_VALID, ISSUE_PHASE, ISSUE_LANE, ISSUE_OP} !== 9'b0) begin
            failures++;
            $display("FAIL reset_issue got=%b want=0",
                     {ISSUE_VALID, ISSUE_PHASE, ISSUE_LANE, ISSUE_OP});
        end
        checks++;
        if ({WB_VALID, WB_PHASE, WB_LANE} !== 6'b0) begin
            failures++;
            $display("FAIL reset_wb got=%b want=0", {WB_VALID, WB_PHASE, WB_LANE});
        end
        checks++;
        if ({DONE0, DONE1} !== 2'b00) begin
            failures++;
            $display("FAIL reset_done got=%b want=00", {DONE0, DONE1});
        end
        RST = 1'b0;
        tick();
        checks++;
        if ({REQ0_READY, REQ1_READY, ISSUE_VALID, WB_VALID} !== 4'b1100) begin
            failures++;
            $display("FAIL reset_idle got=%b want=1100",
                     {REQ0_READY, REQ1_READY, ISSUE_VALID, WB_VALID});
        end
    endtask

    task automatic test_single;
        logic [3:0] exp_l [3];
        exp_l = '{4'b1000, 4'b0010, 4'b0001};
        do_reset();
        REQ0_VALID = 1'b1; REQ0_MASK = 4'b1011; REQ0_OP = 3'd2;
        tick();
        REQ0_VALID = 1'b0;
        checks++;
        if ({REQ0_READY, ISSUE_VALID} !== 2'b00) begin
            failures++;
            $display("FAIL single_accept got=%b want=00", {REQ0_READY, ISSUE_VALID});
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({ISSUE_VALID, ISSUE_PHASE, ISSUE_LANE, ISSUE_OP} !==
                {1'b1, 1'b0, exp_l[k], 3'd2}) begin
                failures++;
                $display("FAIL single_issue k=%0d got=%b want=%b", k,
                         {ISSUE_VALID, ISSUE_PHASE, ISSUE_LANE, ISSUE_OP},
                         {1'b1, 1'b0, exp_l[k], 3'd2});
            end
        end
        checks++;
        if (REQ0_READY !== 1'b1) begin
            failures++;
            $display("FAIL single_ready got=%b want=1", REQ0_READY);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({WB_VALID, WB_PHASE, WB_LANE, DONE0, ISSUE_VALID} !==
                {1'b1, 1'b0, exp_l[k], 1'(k == 2), 1'b0}) begin
                failures++;
                $display("FAIL single_wb k=%0d got=%b want=%b", k,
                         {WB_VALID, WB_PHASE, WB_LANE, DONE0, ISSUE_VALID},
                         {1'b1, 1'b0, exp_l[k], 1'(k == 2), 1'b0});
            end
        end
        tick();
        checks++;
        if ({WB_VALID, DONE0} !== 2'b00) begin
            failures++;
            $display("FAIL single_tail got=%b want=00", {WB_VALID, DONE0});
        end
    endtask

    task automatic test_dual;
        logic [3:0]      ln;
        logic            ph;
        logic [OP_W-1:0] op;
        do_reset();
        REQ0_VALID = 1'b1; REQ0_MASK = 4'b1111; REQ0_OP = 3'd1;
        REQ1_VALID = 1'b1; REQ1_MASK = 4'b1111; REQ1_OP = 3'd5;
        tick();
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            ph = 1'((c - 1) % 2);
            ln = 4'b1000 >> ((c - 1) / 2);
            op = ph ? 3'd5 : 3'd1;
            checks++;
            if (c <= 8) begin
                if ({ISSUE_VALID, ISSUE_PHASE, ISSUE_LANE, ISSUE_OP} !==
                    {1'b1, ph, ln, op}) begin
                    failures++;
                    $display("FAIL dual_issue c=%0d got=%b want=%b", c,
                             {ISSUE_VALID, ISSUE_PHASE, ISSUE_LANE, ISSUE_OP},
                             {1'b1, ph, ln, op});
                end
            end else if (ISSUE_VALID !== 1'b0) begin
                failures++;
                $display("FAIL dual_idle c=%0d got=%b want=0", c, ISSUE_VALID);
            end
            checks++;
            if ({DONE0, DONE1} !== {1'(c == 10), 1'(c == 11)}) begin
                failures++;
                $display("FAIL dual_done c=%0d got=%b want=%b", c,
                         {DONE0, DONE1}, {1'(c == 10), 1'(c == 11)});
            end
        end
    endtask

    task automatic test_hold;
        bit         eiv, ewv;
        logic [3:0] eil, ewl;
        do_reset();
        REQ1_VALID = 1'b1; REQ1_MASK = 4'b0110; REQ1_OP = 3'd3;
        tick();
        REQ1_VALID = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            eiv = (c == 1) || (c == 4);
            eil = (c == 1) ? 4'b0100 : 4'b0010;
            ewv = (c == 4) || (c == 7);
            ewl = (c == 4) ? 4'b0100 : 4'b0010;
            checks++;
            if (ISSUE_VALID !== eiv ||
                (eiv && {ISSUE_PHASE, ISSUE_LANE} !== {1'b1, eil})) begin
                failures++;
                $display("FAIL hold_issue c=%0d got=%b want=%b", c,
                         {ISSUE_VALID, ISSUE_PHASE, ISSUE_LANE}, {eiv, 1'b1, eil});
            end
            checks++;
            if (WB_VALID !== ewv || (ewv && {WB_PHASE, WB_LANE} !== {1'b1, ewl})) begin
                failures++;
                $display("FAIL hold_wb c=%0d got=%b want=%b", c,
                         {WB_VALID, WB_PHASE, WB_LANE}, {ewv, 1'b1, ewl});
            end
            checks++;
            if ({DONE0, DONE1} !== {1'b0, 1'(c == 7)}) begin
                failures++;
                $display("FAIL hold_done c=%0d got=%b want=%b", c,
                         {DONE0, DONE1}, {1'b0, 1'(c == 7)});
            end
            if (c == 1) HOLD = 1'b1;
            if (c == 3) HOLD = 1'b0;
        end
    endtask

    task automatic test_zero;
        do_reset();
        REQ0_VALID = 1'b1; REQ0_MASK = 4'b0000; REQ0_OP = 3'd7;
        tick();
        REQ0_VALID = 1'b0;
        checks++;
        if ({REQ0_READY, DONE0, ISSUE_VALID, DONE1} !== 4'b0100) begin
            failures++;
            $display("FAIL zero_pulse got=%b want=0100",
                     {REQ0_READY, DONE0, ISSUE_VALID, DONE1});
        end
        for (int c = 2; c <= 6; c++) begin
            tick();
            checks++;
            if ({REQ0_READY, DONE0, ISSUE_VALID, WB_VALID} !== 4'b1000) begin
                failures++;
                $display("FAIL zero_after c=%0d got=%b want=1000", c,
                         {REQ0_READY, DONE0, ISSUE_VALID, WB_VALID});
            end
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        REQ0_VALID = 1'b1; REQ0_MASK = 4'b1111; REQ0_OP = 3'd4;
        tick();
        REQ0_VALID = 1'b0;
        tick();
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if ({ISSUE_VALID, WB_VALID, DONE0, DONE1, REQ0_READY, REQ1_READY} !== 6'b000011) begin
            failures++;
            $display("FAIL midrst_state got=%b want=000011",
                     {ISSUE_VALID, WB_VALID, DONE0, DONE1, REQ0_READY, REQ1_READY});
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if ({ISSUE_VALID, WB_VALID, DONE0} !== 3'b000) begin
                failures++;
                $display("FAIL midrst_stale c=%0d got=%b want=000", c,
                         {ISSUE_VALID, WB_VALID, DONE0});
            end
        end
    endtask

    task automatic test_back_to_back;
        bit         eiv, ewv;
        logic [3:0] ewl;
        do_reset();
        REQ0_VALID = 1'b1; REQ0_MASK = 4'b0001; REQ0_OP = 3'd4;
        tick();
        REQ0_VALID = 1'b0;
        tick();
        checks++;
        if ({ISSUE_VALID, ISSUE_LANE, ISSUE_OP, REQ0_READY} !==
            {1'b1, 4'b0001, 3'd4, 1'b1}) begin
            failures++;
            $display("FAIL b2b_first got=%b want=%b",
                     {ISSUE_VALID, ISSUE_LANE, ISSUE_OP, REQ0_READY},
                     {1'b1, 4'b0001, 3'd4, 1'b1});
        end
        REQ0_VALID = 1'b1; REQ0_MASK = 4'b1000; REQ0_OP = 3'd6;
        tick();
        REQ0_VALID = 1'b0;
        checks++;
        if ({ISSUE_VALID, REQ0_READY} !== 2'b00) begin
            failures++;
            $display("FAIL b2b_gap got=%b want=00", {ISSUE_VALID, REQ0_READY});
        end
        for (int c = 3; c <= 8; c++) begin
            tick();
            eiv = (c == 3);
            ewv = (c == 4) || (c == 6);
            ewl = (c == 4) ? 4'b0001 : 4'b1000;
            checks++;
            if (ISSUE_VALID !== eiv ||
                (eiv && {ISSUE_LANE, ISSUE_OP} !== {4'b1000, 3'd6})) begin
                failures++;
                $display("FAIL b2b_issue c=%0d got=%b want=%b", c,
                         {ISSUE_VALID, ISSUE_LANE, ISSUE_OP}, {eiv, 4'b1000, 3'd6});
            end
            checks++;
            if (WB_VALID !== ewv || DONE0 !== ewv ||
                (ewv && {WB_PHASE, WB_LANE} !== {1'b0, ewl})) begin
                failures++;
                $display("FAIL b2b_wb c=%0d got=%b want=%b", c,
                         {WB_VALID, DONE0, WB_PHASE, WB_LANE}, {ewv, ewv, 1'b0, ewl});
            end
        end
    endtask

    task automatic test_random;
        bit              r, v0, v1, h;
        logic [3:0]      k0, k1;
        logic [OP_W-1:0] o0, o1;
        bit              ed0, ed1, er0, er1;
        m_cyc = 0;
        for (int i = 0; i < 800; i++) begin
            r  = (i == 0) || ($urandom_range(0, 79) == 0);
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            k0 = ($urandom_range(0, 7) == 0) ? 4'b0 : 4'($urandom);
            k1 = ($urandom_range(0, 7) == 0) ? 4'b0 : 4'($urandom);
            o0 = OP_W'($urandom);
            o1 = OP_W'($urandom);
            h  = ($urandom_range(0, 4) == 0);
            RST = r; HOLD = h;
            REQ0_VALID = v0; REQ0_MASK = k0; REQ0_OP = o0;
            REQ1_VALID = v1; REQ1_MASK = k1; REQ1_OP = o1;
            @(posedge CLK);
            model_edge(r, v0, v1, k0, k1, o0, o1, h);
            #1;
            ed0 = (e_wv && e_wlst && !e_wp) || m_zero[0];
            ed1 = (e_wv && e_wlst &&  e_wp) || m_zero[1];
            er0 = (mq0.size() == 0) && !m_zero[0];
            er1 = (mq1.size() == 0) && !m_zero[1];
            checks++;
            if ({ISSUE_VALID, ISSUE_PHASE, ISSUE_LANE, ISSUE_OP} !==
                {e_iv, e_ip, e_il, e_io}) begin
                failures++;
                $display("FAIL rand_issue i=%0d got=%b want=%b", i,
                         {ISSUE_VALID, ISSUE_PHASE, ISSUE_LANE, ISSUE_OP},
                         {e_iv, e_ip, e_il, e_io});
            end
            checks++;
            if (WB_VALID !== e_wv || (e_wv && {WB_PHASE, WB_LANE} !== {e_wp, e_wl})) begin
                failures++;
                $display("FAIL rand_wb i=%0d got=%b want=%b", i,
                         {WB_VALID, WB_PHASE, WB_LANE}, {e_wv, e_wp, e_wl});
            end
            checks++;
            if ({REQ0_READY, REQ1_READY, DONE0, DONE1} !== {er0, er1, ed0, ed1}) begin
                failures++;
                $display("FAIL rand_ctrl i=%0d got=%b want=%b", i,
                         {REQ0_READY, REQ1_READY, DONE0, DONE1}, {er0, er1, ed0, ed1});
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_dual();
        test_hold();
        test_zero();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mtsp_sf_sequencer.md
# mtsp_sf_sequencer

Issue sequencer and arbiter for the MTSP special-function (SF) unit. The SF datapath accepts one scalar lane per cycle, while the instruction issue stage presents whole 4-lane (X,Y,Z,W) SF instructions on two phases (thread phase #0 and #1). This block accepts one instruction per phase, serializes its enabled lanes, and arbitrates the single shared SF issue slot between the phases with round-robin. It also tracks the fixed 3-stage SF pipeline (SM, EX0, EX1) to produce per-lane write-back enables and an instruction-complete pulse per phase.

## Interface
Parameters:
- SF_LATENCY, 3, cycles from an ISSUE_VALID cycle to the matching WB_VALID cycle; fixed SF pipeline depth.
- OP_W, 3, width of the SF opcode field (RCP/RSQ/MAN/EXP select).

Ports:
- CLK  in  1  main clock, all logic on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- REQ0_VALID, REQ1_VALID  in  1  phase #0/#1 SF instruction valid.
- REQ0_READY, REQ1_READY  out  1  phase #0/#1 can accept an instruction.
- REQ0_MASK, REQ1_MASK  in  4  lane enables; bit3=X, bit2=Y, bit1=Z, bit0=W.
- REQ0_OP, REQ1_OP  in  OP_W  SF opcode.
- HOLD  in  1  downstream stall; suppresses new issues.
- ISSUE_VALID  out  1  SF slot carries a lane this cycle.
- ISSUE_PHASE  out  1  phase of the issued lane.
- ISSUE_LANE  out  4  one-hot issued lane, same bit order as REQx_MASK.
- ISSUE_OP  out  OP_W  opcode of the issued lane.
- WB_VALID  out  1  SF result for a lane is written this cycle.
- WB_PHASE  out  1  phase of the write-back.
- WB_LANE  out  4  one-hot write-back lane.
- DONE0, DONE1  out  1  one-cycle pulse: last lane of the phase's instruction written back.

## Operation
- Per phase p: registers rem_p (4-bit remaining lanes), op_p, and zero_p (empty-mask flag). REQp_READY = (rem_p == 0) & ~zero_p; purely combinational from state.
- Accept: REQp_VALID & REQp_READY at an edge loads rem_p = REQp_MASK and op_p = REQp_OP. Inputs are ignored when READY is low.
- Empty mask: accepting MASK = 4'b0000 sets zero_p; no issue occurs; DONEp pulses in the next cycle, and zero_p clears at the same time.
- Lane select per phase: the highest set bit of rem_p, giving X, then Y, then Z, then W.
- Arbitration: a candidate is a phase with rem_p != 0.
  - If both phases are candidates, grant the phase opposite to pointer `last`.
  - If only one is a candidate, grant that phase.
  - `last` updates to the granted phase on every grant.
- Grant occurs only when HOLD = 0. On grant, the selected bit is cleared from rem_p. ISSUE_* are registered from the grant.
- If HOLD = 1, or there is no candidate, ISSUE_VALID = 0 next cycle and the other ISSUE_* fields hold their previous values.
- Pipeline tracking: a SF_LATENCY-deep shift register of {valid, phase, lane, last}, where last = (remaining bits of rem_p after clearing == 0).
  - The register advances every cycle regardless of HOLD, because the SF pipeline never stalls.
  - The stage output drives WB_*. DONEp = WB_VALID & last & (WB_PHASE == p).
- Simultaneous events:
  - A phase may accept a new instruction in the cycle after its last lane is granted, while earlier lanes are still in flight.
  - DONE of an old instruction and a grant for a new one on the same phase may coincide.
  - A DONE pulse on one phase and a zero-mask DONE on the other phase may also coincide. Each DONEp is independent.
- Reset at any point, including mid-instruction, discards everything in flight:
  - rem_p and zero_p clear, and the pipeline valids clear.
  - `last` resets to 1, so phase #0 wins the first contention.

## Timing
- Reset values: REQ0_READY = REQ1_READY = 1 after the reset edge. ISSUE_VALID = 0, ISSUE_PHASE = 0, ISSUE_LANE = 0, ISSUE_OP = 0, WB_VALID = 0, WB_PHASE = 0, WB_LANE = 0, DONE0 = DONE1 = 0.
- Accept at edge E0: the first ISSUE_VALID is visible after edge E1. Its write-back is visible after E1+SF_LATENCY (E4).
- An n-lane instruction on an uncontended phase with HOLD = 0 issues on n consecutive cycles and pulses DONE after E(n+3).
- Best-case throughput is one lane per cycle total.
- HOLD asserted before edge Ek leaves rem unchanged at Ek and gives ISSUE_VALID = 0 after Ek. Write-backs already in flight still appear on schedule.

## Test plan
- Reset, then phase 0 MASK = 4'b1011, OP = 3'd2. Required: ISSUE_LANE = 1000, 0010, 0001 on three consecutive cycles starting one cycle after accept. WB_LANE follows in the same order three cycles later. DONE0 pulses together with WB_LANE = 0001. REQ0_READY returns high the cycle after the W grant.
- Both phases MASK = 4'b1111, accepted on the same edge after reset. Required: ISSUE sequence (phase, lane) = 0X, 1X, 0Y, 1Y, 0Z, 1Z, 0W, 1W. DONE0 pulses one cycle before DONE1.
- Phase 1 MASK = 4'b0110 with HOLD = 1 for 2 cycles starting at the second issue. Required: Y issued, then 2 idle issue cycles, then Z. WB for Y is unaffected by HOLD. DONE1 occurs 2 cycles later than the no-HOLD case.
- Phase 0 MASK = 4'b0000. Required: no ISSUE_VALID, and DONE0 pulses exactly one cycle after the accept. REQ0_READY is low for exactly that one cycle.
- Phase 0 MASK = 4'b1111, with RST asserted after the second issue. Required: the cycle after reset has ISSUE_VALID = 0, WB_VALID = 0, DONE0 = 0 and both READY = 1. No stale write-backs appear afterwards.
- Back-to-back on phase 0: MASK = 4'b0001 then MASK = 4'b1000, with the second accepted the cycle after the first grant. Required: issues on two consecutive-plus-one cycles (W, gap, X). Two DONE0 pulses follow, each with its own WB.
